// File: rtl/pipelined_addsub_if.sv
// rtl/pipelined_addsub_if.sv - operand/result valid-ready bundle for pipelined_addsub
interface pipelined_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Producer/consumer side: issues operands and accepts results.
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // Arithmetic unit side.
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - chunked ripple add/sub pipeline; PIPELINED_ADDSUB_SAT_EN enables signed saturation
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst,
    pipelined_addsub_if.slave bus
);
    localparam int CW = WIDTH / STAGES;

    logic             adv;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // The whole pipeline moves as one; a stalled result freezes every stage.
    assign adv           = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        // Operand bits still to be consumed from this stage onward.
        localparam int IW = WIDTH - k * CW;

        logic [IW-1:0] a_cur;
        logic [IW-1:0] b_cur;
        logic          c_cur;
        logic          v_cur;
        logic [CW:0]   add;

        if (k == 0) begin : g_src
            // Subtraction is a + ~b + ~cin, so b and cin are conditioned up front.
            assign a_cur = bus.a;
            assign b_cur = bus.sub ? ~bus.b : bus.b;
            assign c_cur = bus.cin ^ bus.sub;
            assign v_cur = bus.in_valid;
        end else begin : g_src
            assign a_cur = stg[k-1].g_reg.a_q;
            assign b_cur = stg[k-1].g_reg.b_q;
            assign c_cur = stg[k-1].g_reg.c_q;
            assign v_cur = stg[k-1].g_reg.v_q;
        end

        assign add = {1'b0, a_cur[CW-1:0]} + {1'b0, b_cur[CW-1:0]} + {{CW{1'b0}}, c_cur};

        if (k < STAGES - 1) begin : g_reg
            // Upper operand chunks skew forward; finished low sum chunks de-skew forward.
            localparam int RW = IW - CW;
            localparam int SW = (k + 1) * CW;

            logic [RW-1:0] a_q;
            logic [RW-1:0] b_q;
            logic [SW-1:0] s_q;
            logic [SW-1:0] s_nxt;
            logic          c_q;
            logic          v_q;

            if (k == 0) begin : g_s
                assign s_nxt = add[CW-1:0];
            end else begin : g_s
                assign s_nxt = {add[CW-1:0], stg[k-1].g_reg.s_q};
            end

            // Intermediate stage register: loads on advance, valid bit cleared by reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (adv) begin
                    a_q <= a_cur[IW-1:CW];
                    b_q <= b_cur[IW-1:CW];
                    s_q <= s_nxt;
                    c_q <= add[CW];
                    v_q <= v_cur;
                end
            end
        end else begin : g_out
            logic [WIDTH-1:0] res;
            logic [WIDTH-1:0] sum_nxt;
            logic             c_msb;
            logic             ovf_nxt;

            if (STAGES == 1) begin : g_res
                assign res = add[CW-1:0];
            end else begin : g_res
                assign res = {add[CW-1:0], stg[k-1].g_reg.s_q};
            end

            // Carry into the MSB is recovered from the MSB's own sum bit.
            assign c_msb   = a_cur[CW-1] ^ b_cur[CW-1] ^ add[CW-1];
            assign ovf_nxt = c_msb ^ add[CW];

`ifdef PIPELINED_ADDSUB_SAT_EN
            // A wrapped sign bit of 0 means the true result was below the most negative value.
            assign sum_nxt = !ovf_nxt    ? res :
                             res[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} :
                                            {1'b1, {(WIDTH-1){1'b0}}};
`else
            assign sum_nxt = res;
`endif

            // Result register: holds steady while downstream stalls.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    sum_q       <= '0;
                    cout_q      <= 1'b0;
                    ovf_q       <= 1'b0;
                end else if (adv) begin
                    out_valid_q <= v_cur;
                    sum_q       <= sum_nxt;
                    cout_q      <= add[CW];
                    ovf_q       <= ovf_nxt;
                end
            end
        end
    end
endmodule
